// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the RAM-port controller.
package mem_ctrl_pkg;

    localparam int unsigned XLEN_DEF       = 32;
    localparam int unsigned IO_SEL_LSB_DEF = 16;

    // Value of the two address-select bits that marks the IO region.
    localparam logic [1:0] IO_SEL_VAL = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StInstRd,
        StDataRd,
        StDataWr
    } state_e;

    typedef enum logic [1:0] {
        WidthByte = 2'd0,
        WidthHalf = 2'd1,
        WidthWord = 2'd2
    } width_e;

    typedef enum logic {
        GrantInst = 1'b0,
        GrantData = 1'b1
    } grant_e;

    // Number of bytes moved by a data access of the given width code.
    function automatic logic [2:0] width_bytes(input logic [1:0] w);
        logic [2:0] n;
        case (width_e'(w))
            WidthByte: n = 3'd1;
            WidthHalf: n = 3'd2;
            default:   n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl_arbiter.sv
// Two-way round-robin arbiter between the icache refill path and the LSB.
module mem_ctrl_arbiter
    import mem_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rdy_i,
    input  logic en_i,
    input  logic req_inst_i,
    input  logic req_data_i,
    output logic grant_inst_o,
    output logic grant_data_o
);

    grant_e last_grant_q, last_grant_d;

    // Sole requester wins; on a tie the side that did not win last time goes.
    always_comb begin
        grant_inst_o = 1'b0;
        grant_data_o = 1'b0;
        if (en_i) begin
            if (req_inst_i && req_data_i) begin
                if (last_grant_q == GrantInst) begin
                    grant_data_o = 1'b1;
                end else begin
                    grant_inst_o = 1'b1;
                end
            end else begin
                grant_inst_o = req_inst_i;
                grant_data_o = req_data_i;
            end
        end
    end

    // Remember the most recent winner.
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_inst_o) begin
            last_grant_d = GrantInst;
        end else if (grant_data_o) begin
            last_grant_d = GrantData;
        end
    end

    // Reset to GrantInst so data wins the first tie.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_grant_q <= GrantInst;
        end else if (rdy_i) begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide RAM port controller shared by instruction refills and LSB accesses.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned IO_SEL_LSB = IO_SEL_LSB_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    input  logic            io_buffer_full,
    input  logic            fet_mem_enable,
    input  logic [XLEN-1:0] fet_mem_addr,
    input  logic            lsb_mem_enable,
    input  logic            lsb_mem_wr,
    input  logic [1:0]      lsb_mem_width,
    input  logic [XLEN-1:0] lsb_mem_addr,
    input  logic [XLEN-1:0] lsb_mem_data,
    input  logic [7:0]      mem_din,
    output logic [7:0]      mem_dout,
    output logic [XLEN-1:0] mem_a,
    output logic            mem_wr,
    output logic            mem_inst_ready,
    output logic [XLEN-1:0] mem_inst,
    output logic [XLEN-1:0] mem_inst_addr,
    output logic            lsb_mem_ready,
    output logic [XLEN-1:0] lsb_mem_result
);

    state_e          state_q, state_d;
    logic [2:0]      cyc_q, cyc_d;       // reads: cycle number; writes: bytes issued
    logic [2:0]      len_q, len_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] asm_q, asm_d;       // read data being assembled
    logic [XLEN-1:0] mem_a_q, mem_a_d;
    logic [7:0]      mem_dout_q, mem_dout_d;
    logic            mem_wr_q, mem_wr_d;
    logic            inst_ready_q, inst_ready_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_addr_q, inst_addr_d;
    logic            lsb_ready_q, lsb_ready_d;
    logic [XLEN-1:0] result_q, result_d;

    // The RAM keeps answering while rdy is low, so the byte that arrives in the
    // first stalled cycle is parked and replayed on resume.
    logic            stalled_q;
    logic [7:0]      din_hold_q;
    logic [7:0]      din_eff;

    logic            grant_inst, grant_data;
    logic            arb_en;
    logic            req_io, cur_io;
    logic [2:0]      cap_idx;
    logic [XLEN-1:0] din_shift;
    logic [XLEN-1:0] wshift;

    assign arb_en    = (state_q == StIdle) && !flush;
    assign req_io    = (lsb_mem_addr[IO_SEL_LSB +: 2] == IO_SEL_VAL);
    assign cur_io    = (addr_q[IO_SEL_LSB +: 2] == IO_SEL_VAL);
    assign din_eff   = stalled_q ? din_hold_q : mem_din;
    assign cap_idx   = cyc_q - 3'd2;
    assign din_shift = XLEN'(din_eff) << {cap_idx[1:0], 3'b000};
    assign wshift    = wdata_q >> {cyc_q[1:0], 3'b000};

    mem_ctrl_arbiter u_arbiter (
        .clk_i        (clk),
        .rst_ni       (rst),
        .rdy_i        (rdy),
        .en_i         (arb_en),
        .req_inst_i   (fet_mem_enable),
        .req_data_i   (lsb_mem_enable),
        .grant_inst_o (grant_inst),
        .grant_data_o (grant_data)
    );

    // Next-state and registered-output computation for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        len_d        = len_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        asm_d        = asm_q;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        mem_wr_d     = 1'b0;
        inst_ready_d = 1'b0;
        inst_d       = inst_q;
        inst_addr_d  = inst_addr_q;
        lsb_ready_d  = 1'b0;
        result_d     = result_q;

        unique case (state_q)
            StIdle: begin
                if (grant_data) begin
                    addr_d  = lsb_mem_addr;
                    wdata_d = lsb_mem_data;
                    len_d   = width_bytes(lsb_mem_width);
                    asm_d   = '0;
                    if (lsb_mem_wr) begin
                        state_d = StDataWr;
                        cyc_d   = 3'd0;
                        if (!(req_io && io_buffer_full)) begin
                            mem_wr_d   = 1'b1;
                            mem_a_d    = lsb_mem_addr;
                            mem_dout_d = lsb_mem_data[7:0];
                            cyc_d      = 3'd1;
                        end
                    end else begin
                        state_d = StDataRd;
                        mem_a_d = lsb_mem_addr;
                        cyc_d   = 3'd1;
                    end
                end else if (grant_inst) begin
                    state_d = StInstRd;
                    addr_d  = fet_mem_addr;
                    mem_a_d = fet_mem_addr;
                    asm_d   = '0;
                    cyc_d   = 3'd1;
                end
            end

            StInstRd: begin
                if (inst_ready_q || flush) begin
                    state_d = StIdle;
                end else begin
                    cyc_d = cyc_q + 3'd1;
                    if (cyc_q >= 3'd2) begin
                        asm_d = asm_q | din_shift;
                    end
                    case (cyc_q)
                        3'd1: mem_a_d = addr_q + XLEN'(1);
                        3'd2: mem_a_d = addr_q + XLEN'(2);
                        3'd3: begin
                            // Low byte is in; its two LSBs say whether this is RVC.
                            if (asm_q[1:0] != 2'b11) begin
                                inst_ready_d = 1'b1;
                                inst_d       = asm_d;
                                inst_addr_d  = addr_q;
                            end else begin
                                mem_a_d = addr_q + XLEN'(3);
                            end
                        end
                        3'd5: begin
                            inst_ready_d = 1'b1;
                            inst_d       = asm_d;
                            inst_addr_d  = addr_q;
                        end
                        default: ;
                    endcase
                end
            end

            StDataRd: begin
                if (lsb_ready_q || flush) begin
                    state_d = StIdle;
                end else begin
                    if (cyc_q >= 3'd2) begin
                        asm_d = asm_q | din_shift;
                    end
                    if (cyc_q < len_q) begin
                        mem_a_d = addr_q + XLEN'(cyc_q);
                    end
                    if (cyc_q == len_q + 3'd1) begin
                        lsb_ready_d = 1'b1;
                        result_d    = asm_d;
                    end else begin
                        cyc_d = cyc_q + 3'd1;
                    end
                end
            end

            StDataWr: begin
                // Stores are already committed, so flush is ignored here.
                if (lsb_ready_q) begin
                    state_d = StIdle;
                end else if (cyc_q == len_q) begin
                    lsb_ready_d = 1'b1;
                end else if (!(cur_io && io_buffer_full)) begin
                    mem_wr_d   = 1'b1;
                    mem_a_d    = addr_q + XLEN'(cyc_q);
                    mem_dout_d = wshift[7:0];
                    cyc_d      = cyc_q + 3'd1;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // State update; everything except the stall tracker freezes while rdy is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            cyc_q        <= '0;
            len_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            asm_q        <= '0;
            mem_a_q      <= '0;
            mem_dout_q   <= '0;
            mem_wr_q     <= 1'b0;
            inst_ready_q <= 1'b0;
            inst_q       <= '0;
            inst_addr_q  <= '0;
            lsb_ready_q  <= 1'b0;
            result_q     <= '0;
            stalled_q    <= 1'b0;
            din_hold_q   <= '0;
        end else begin
            stalled_q <= !rdy;
            if (!rdy && !stalled_q) begin
                din_hold_q <= mem_din;
            end
            if (rdy) begin
                state_q      <= state_d;
                cyc_q        <= cyc_d;
                len_q        <= len_d;
                addr_q       <= addr_d;
                wdata_q      <= wdata_d;
                asm_q        <= asm_d;
                mem_a_q      <= mem_a_d;
                mem_dout_q   <= mem_dout_d;
                mem_wr_q     <= mem_wr_d;
                inst_ready_q <= inst_ready_d;
                inst_q       <= inst_d;
                inst_addr_q  <= inst_addr_d;
                lsb_ready_q  <= lsb_ready_d;
                result_q     <= result_d;
            end
        end
    end

    assign mem_a          = mem_a_q;
    assign mem_dout       = mem_dout_q;
    assign mem_wr         = mem_wr_q & rdy;
    assign mem_inst_ready = inst_ready_q;
    assign mem_inst       = inst_q;
    assign mem_inst_addr  = inst_addr_q;
    assign lsb_mem_ready  = lsb_ready_q;
    assign lsb_mem_result = result_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl with a byte-wide RAM model (one-cycle read latency).
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, io_buffer_full;
    logic        fet_mem_enable;
    logic [31:0] fet_mem_addr;
    logic        lsb_mem_enable, lsb_mem_wr;
    logic [1:0]  lsb_mem_width;
    logic [31:0] lsb_mem_addr, lsb_mem_data;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        mem_inst_ready;
    logic [31:0] mem_inst, mem_inst_addr;
    logic        lsb_mem_ready;
    logic [31:0] lsb_mem_result;

    mem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .flush          (flush),
        .io_buffer_full (io_buffer_full),
        .fet_mem_enable (fet_mem_enable),
        .fet_mem_addr   (fet_mem_addr),
        .lsb_mem_enable (lsb_mem_enable),
        .lsb_mem_wr     (lsb_mem_wr),
        .lsb_mem_width  (lsb_mem_width),
        .lsb_mem_addr   (lsb_mem_addr),
        .lsb_mem_data   (lsb_mem_data),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_inst_ready (mem_inst_ready),
        .mem_inst       (mem_inst),
        .mem_inst_addr  (mem_inst_addr),
        .lsb_mem_ready  (lsb_mem_ready),
        .lsb_mem_result (lsb_mem_result)
    );

    always #5 clk = ~clk;

    // RAM model: low 16 address bits, read data valid the cycle after the address.
    logic [7:0] ram [0:65535];
    bit         ram_init_done = 1'b0;
    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
            ram[16'h1000] = 8'h11; ram[16'h1001] = 8'h22;
            ram[16'h1002] = 8'h33; ram[16'h1003] = 8'h44;
            ram[16'h0200] = 8'h01; ram[16'h0201] = 8'h45;
            ram[16'h0204] = 8'h13; ram[16'h0205] = 8'h05;
            ram[16'h0206] = 8'h10; ram[16'h0207] = 8'h00;
            ram_init_done = 1'b1;
        end
        mem_din <= ram[mem_a[15:0]];
        if (mem_wr) ram[mem_a[15:0]] = mem_dout;
    end

    typedef struct {
        logic [31:0] val;
        logic [31:0] addr;
        int          cyc;
        bit          chk_val;
    } exp_t;

    exp_t exp_lsb[$];
    exp_t exp_inst[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   gcyc     = 0;
    int   t0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, gcyc);
        end
    endtask

    // Advance one cycle, sample at the falling edge and retire scoreboard entries.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        gcyc++;
        if (lsb_mem_ready) begin
            if (exp_lsb.size() == 0) begin
                check_eq("lsb_ready_spurious", 32'(lsb_mem_ready), 32'd0);
            end else begin
                e = exp_lsb.pop_front();
                check_eq("lsb_ready_cycle", 32'(gcyc), 32'(e.cyc));
                if (e.chk_val) check_eq("lsb_result", lsb_mem_result, e.val);
            end
            lsb_mem_enable = 1'b0;
        end
        if (mem_inst_ready) begin
            if (exp_inst.size() == 0) begin
                check_eq("inst_ready_spurious", 32'(mem_inst_ready), 32'd0);
            end else begin
                e = exp_inst.pop_front();
                check_eq("inst_ready_cycle", 32'(gcyc), 32'(e.cyc));
                check_eq("inst_value", mem_inst, e.val);
                check_eq("inst_addr", mem_inst_addr, e.addr);
            end
            fet_mem_enable = 1'b0;
        end
        if (exp_lsb.size() != 0 && exp_lsb[0].cyc < gcyc) begin
            e = exp_lsb.pop_front();
            check_eq("lsb_ready_missed", 32'(gcyc), 32'(e.cyc));
        end
        if (exp_inst.size() != 0 && exp_inst[0].cyc < gcyc) begin
            e = exp_inst.pop_front();
            check_eq("inst_ready_missed", 32'(gcyc), 32'(e.cyc));
        end
    endtask

    // Run until every expected pulse has been seen (bounded), then one more cycle.
    task automatic drain(input int max_cyc);
        int n = 0;
        while ((exp_lsb.size() != 0 || exp_inst.size() != 0) && n < max_cyc) begin
            tick();
            n++;
        end
        check_eq("drain_lsb_left", 32'(exp_lsb.size()), 32'd0);
        check_eq("drain_inst_left", 32'(exp_inst.size()), 32'd0);
        exp_lsb.delete();
        exp_inst.delete();
        tick();
    endtask

    task automatic lsb_req(input bit wr, input logic [1:0] w, input logic [31:0] a,
                           input logic [31:0] d);
        lsb_mem_wr     = wr;
        lsb_mem_width  = w;
        lsb_mem_addr   = a;
        lsb_mem_data   = d;
        lsb_mem_enable = 1'b1;
    endtask

    task automatic fet_req(input logic [31:0] a);
        fet_mem_addr   = a;
        fet_mem_enable = 1'b1;
    endtask

    task automatic push_lsb(input logic [31:0] v, input int c, input bit chk);
        exp_t e;
        e.val = v; e.addr = '0; e.cyc = c; e.chk_val = chk;
        exp_lsb.push_back(e);
    endtask

    task automatic push_inst(input logic [31:0] v, input logic [31:0] a, input int c);
        exp_t e;
        e.val = v; e.addr = a; e.cyc = c; e.chk_val = 1'b1;
        exp_inst.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        fet_mem_enable = 1'b0; fet_mem_addr = '0;
        lsb_mem_enable = 1'b0; lsb_mem_wr = 1'b0; lsb_mem_width = '0;
        lsb_mem_addr = '0; lsb_mem_data = '0;

        tick(); tick();
        check_eq("rst_mem_a", mem_a, 32'h0);
        check_eq("rst_mem_wr", 32'(mem_wr), 32'h0);
        check_eq("rst_lsb_ready", 32'(lsb_mem_ready), 32'h0);
        check_eq("rst_inst_ready", 32'(mem_inst_ready), 32'h0);
        rst = 1'b1;
        tick();

        // Word load at 0x1000.
        lsb_req(1'b0, 2'd2, 32'h1000, 32'h0);
        t0 = gcyc;
        push_lsb(32'h44332211, t0 + 6, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_eq($sformatf("ldw_a%0d", c), mem_a, 32'h1000 + 32'(c - 1));
        end
        drain(20);

        // Byte and half loads.
        lsb_req(1'b0, 2'd0, 32'h1002, 32'h0);
        push_lsb(32'h00000033, gcyc + 3, 1'b1);
        drain(20);
        lsb_req(1'b0, 2'd1, 32'h1001, 32'h0);
        push_lsb(32'h00003322, gcyc + 4, 1'b1);
        drain(20);

        // Compressed refill at 0x200.
        fet_req(32'h200);
        t0 = gcyc;
        push_inst(32'h00004501, 32'h200, t0 + 4);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check_eq($sformatf("rvc_a%0d", c), mem_a, 32'h200 + 32'(c - 1));
        end
        drain(20);

        // Full-width refill at 0x204.
        fet_req(32'h204);
        t0 = gcyc;
        push_inst(32'h00100513, 32'h204, t0 + 6);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_eq($sformatf("rv32_a%0d", c), mem_a, 32'h204 + 32'(c - 1));
        end
        drain(20);

        // Reset in the middle of a refill.
        fet_req(32'h200);
        tick(); tick();
        rst = 1'b0;
        fet_mem_enable = 1'b0;
        tick();
        check_eq("mrst_mem_a", mem_a, 32'h0);
        check_eq("mrst_mem_inst", mem_inst, 32'h0);
        check_eq("mrst_inst_addr", mem_inst_addr, 32'h0);
        check_eq("mrst_result", lsb_mem_result, 32'h0);
        check_eq("mrst_inst_ready", 32'(mem_inst_ready), 32'h0);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) tick();

        // Tie after reset: store-half to IO wins, buffer full for 3 cycles.
        fet_req(32'h200);
        lsb_req(1'b1, 2'd1, 32'h00030000, 32'h0000BEEF);
        io_buffer_full = 1'b1;
        t0 = gcyc;
        push_lsb(32'h0, t0 + 6, 1'b0);
        push_inst(32'h00004501, 32'h200, t0 + 11);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check_eq($sformatf("io_hold_wr%0d", c), 32'(mem_wr), 32'h0);
        end
        io_buffer_full = 1'b0;
        tick();
        check_eq("io_wr0", 32'(mem_wr), 32'h1);
        check_eq("io_dout0", 32'(mem_dout), 32'hEF);
        check_eq("io_a0", mem_a, 32'h00030000);
        tick();
        check_eq("io_wr1", 32'(mem_wr), 32'h1);
        check_eq("io_dout1", 32'(mem_dout), 32'hBE);
        check_eq("io_a1", mem_a, 32'h00030001);
        tick(); tick(); tick();
        check_eq("rr_refill_a", mem_a, 32'h200);
        drain(20);

        // Flush in cycle 2 of a word load: aborted, mem_a frozen, no ready.
        lsb_req(1'b0, 2'd2, 32'h1000, 32'h0);
        tick(); tick();
        flush = 1'b1;
        lsb_mem_enable = 1'b0;
        tick();
        flush = 1'b0;
        check_eq("fl_ld_a3", mem_a, 32'h1001);
        for (int c = 0; c < 6; c++) tick();
        check_eq("fl_ld_a_end", mem_a, 32'h1001);

        // Flush during a store: store still completes.
        lsb_req(1'b1, 2'd2, 32'h2000, 32'hA1B2C3D4);
        t0 = gcyc;
        push_lsb(32'h0, t0 + 5, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 2) flush = 1'b1;
            if (c == 3) flush = 1'b0;
            check_eq($sformatf("fl_st_wr%0d", c), 32'(mem_wr), 32'h1);
            check_eq($sformatf("fl_st_a%0d", c), mem_a, 32'h2000 + 32'(c - 1));
        end
        drain(20);
        lsb_req(1'b0, 2'd2, 32'h2000, 32'h0);
        push_lsb(32'hA1B2C3D4, gcyc + 6, 1'b1);
        drain(20);

        // rdy low for 2 cycles mid-load: ready slips by 2, data intact.
        lsb_req(1'b0, 2'd2, 32'h1000, 32'h0);
        t0 = gcyc;
        push_lsb(32'h44332211, t0 + 8, 1'b1);
        tick(); tick(); tick();
        rdy = 1'b0;
        check_eq("stall_a3", mem_a, 32'h1002);
        tick();
        check_eq("stall_a4", mem_a, 32'h1002);
        check_eq("stall_wr", 32'(mem_wr), 32'h0);
        tick();
        rdy = 1'b1;
        drain(20);

        // Flush while idle blocks the grant for that cycle only.
        lsb_req(1'b0, 2'd0, 32'h1000, 32'h0);
        flush = 1'b1;
        t0 = gcyc;
        push_lsb(32'h00000011, t0 + 4, 1'b1);
        tick();
        flush = 1'b0;
        check_eq("fl_idle_a1", mem_a, 32'h1003);
        tick();
        check_eq("fl_idle_a2", mem_a, 32'h1000);
        drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Owns the single byte-wide RAM port and shares it between two requesters: the fetcher/icache refill path and the load-store buffer (LSB).
- Instruction refills return 16 or 32 bits depending on the RVC encoding and drive the icache fill inputs directly.
- Data requests perform 1/2/4-byte loads and stores.
- Sits between the core and the external RAM/IO bus.

Parameters:
XLEN, 32, address/data width
IO_SEL_LSB, 16, addresses with addr[IO_SEL_LSB+1:IO_SEL_LSB]==2'b11 are IO

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset (reset when rst==0 at posedge clk)
rdy  in  1  global enable; low freezes all state
flush  in  1  pipeline flush
io_buffer_full  in  1  IO write buffer full
fet_mem_enable  in  1  instruction refill request, held until mem_inst_ready
fet_mem_addr  in  XLEN  refill address (2-byte aligned)
lsb_mem_enable  in  1  data request, held until lsb_mem_ready
lsb_mem_wr  in  1  1=store, 0=load
lsb_mem_width  in  2  0=byte, 1=half, 2=word
lsb_mem_addr  in  XLEN  data address
lsb_mem_data  in  XLEN  store data (little-endian, low bytes used)
mem_din  in  8  RAM read byte
mem_dout  out  8  RAM write byte
mem_a  out  XLEN  RAM address
mem_wr  out  1  1=write
mem_inst_ready  out  1  one-cycle pulse to icache/fetcher
mem_inst  out  XLEN  {16'b0,lo} if RVC, else full word
mem_inst_addr  out  XLEN  address of mem_inst
lsb_mem_ready  out  1  one-cycle pulse to LSB
lsb_mem_result  out  XLEN  zero-extended load data

Behaviour:
- Reset: state=IDLE; all outputs 0; last_grant=INST, so data wins the first tie.
- rdy low: no state change; mem_wr forced 0.
- RAM timing: a byte addressed on mem_a in cycle t is valid on mem_din in cycle t+1. All outputs are registered.
- States: IDLE, INST_RD, DATA_RD, DATA_WR.
- IDLE: latch the granted request.
  - One requester valid: it wins.
  - Both valid: grant the one not in last_grant (round-robin); update last_grant.
  - Request seen in cycle 0: first mem_a is driven in cycle 1.
- DATA_RD, n = 1/2/4 bytes:
  - mem_a=addr+k in cycles 1..n.
  - Byte k is captured at the end of cycle k+1.
  - lsb_mem_ready is high in cycle n+2, then return to IDLE.
  - No speculative reads; IO reads consume input.
- DATA_WR:
  - mem_wr=1, mem_a=addr+k, mem_dout=data[8k+7:8k] in cycles 1..n.
  - lsb_mem_ready is high in cycle n+1.
  - IO write with io_buffer_full high: hold before driving the byte (mem_wr=0) until it clears.
- INST_RD:
  - mem_a=addr, addr+1, addr+2 in cycles 1..3; the addr+2 read is speculative and harmless (never IO).
  - End of cycle 3: byte1 has been captured; the decision uses low byte[1:0].
  - If low byte[1:0] != 2'b11: mem_inst_ready in cycle 4, mem_inst={16'b0,half}.
  - Otherwise: addr+3 in cycle 4; ready in cycle 6 with the full word.
  - mem_inst_addr = latched addr.
- flush:
  - An in-flight INST_RD or DATA_RD aborts: next state IDLE, no ready pulse.
  - A flush in the same cycle as a pending ready suppresses that ready.
  - DATA_WR always completes, because stores are committed.
  - flush while in IDLE: no grant that cycle.
- Requester dropping enable mid-transaction without flush is ignored; the transaction completes and ready still pulses.
- Back-to-back: the cycle after a ready pulse is IDLE, and arbitration resumes there.
- mem_a is held at its last value in IDLE; mem_wr=0 outside DATA_WR byte cycles.

Decomposition:
- global_params: state encodings, width codes (BYTE/HALF/WORD), IO select constant.
- Sub-module mem_arbiter: two-way round-robin grant with last_grant register and rdy gating.

Test Plan:
- Load word, addr 0x1000, RAM bytes 11,22,33,44 -> mem_a 0x1000..0x1003 in cycles 1-4; lsb_mem_ready in cycle 6; result 0x44332211.
- Refill at 0x200, bytes 0x01,0x45 -> mem_inst_ready in cycle 4; mem_inst=0x00004501; mem_inst_addr=0x200.
- Refill at 0x204, bytes 0x13,0x05,0x10,0x00 -> ready in cycle 6; mem_inst=0x00100513.
- Fetch and store-half (0x30000, 0xBEEF) both requested after reset -> store first with mem_wr=1, dout EF then BE. If io_buffer_full is held 3 cycles, the write is delayed 3 cycles. Refill is granted the cycle after lsb_mem_ready.
- Flush in cycle 2 of a word load -> no lsb_mem_ready; IDLE in cycle 3. Flush during a store -> store completes and ready pulses.
- rst=0 mid-refill -> IDLE next cycle, all outputs 0, no ready. rdy=0 for 2 cycles mid-load -> ready delayed exactly 2 cycles, result unchanged.
